// File: rtl/a2d_edge_rx.sv
// Analog-to-digital edge receiver: hysteresis comparator with confirm filter, timestamped event FIFO.
// Latency: out and the event update on the clock edge that samples the confirming code.
// Backpressure: 4-entry event FIFO; a push into a full FIFO is dropped and latches evt_ovf.
// Optional macro A2D_XFLAG_EN adds the indeterminate-band watchdog driving x_flag.
module a2d_edge_rx #(
  parameter int CODE_W    = 12,
  parameter int VTH_HI    = 2048,
  parameter int VTH_LO    = 1024,
  parameter int CONFIRM   = 2,
  parameter int TS_W      = 16,
  parameter int INIT_V    = 0,
  parameter int X_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              smp_valid,
  input  logic [CODE_W-1:0] smp_code,
  output logic              out,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_level,
  output logic [TS_W-1:0]   evt_ts,
  output logic              evt_ovf,
  output logic              x_flag
);

  localparam logic [CODE_W-1:0] HI_C    = CODE_W'(VTH_HI);
  localparam logic [CODE_W-1:0] LO_C    = CODE_W'(VTH_LO);
  localparam logic [3:0]        CNT_CFM = 4'(CONFIRM);

  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;

  typedef struct packed {
    logic            level;
    logic [TS_W-1:0] ts;
  } evt_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  logic            out_q;
  logic [TS_W-1:0] ts_q;
  logic            is_hi;
  logic            is_lo;
  logic            rise_cfm;
  logic            fall_cfm;
  logic            push;

  evt_t            mem_q [4];
  logic [1:0]      wr_ptr_q;
  logic [1:0]      rd_ptr_q;
  logic [2:0]      fill_q;
  logic            ovf_q;
  logic            full;
  logic            pop;
  logic            push_ok;

  // Threshold compares and detection of the sample that completes a confirmed transition
  always_comb begin
    is_hi    = (smp_code >= HI_C);
    is_lo    = (smp_code <= LO_C);
    cnt_d    = cnt_q + 4'd1;
    rise_cfm = 1'b0;
    fall_cfm = 1'b0;
    if (smp_valid) begin
      rise_cfm = is_hi && (((state_q == LOW) && (CONFIRM == 1)) ||
                           ((state_q == RISE_PEND) && (cnt_d == CNT_CFM)));
      fall_cfm = is_lo && (((state_q == HIGH) && (CONFIRM == 1)) ||
                           ((state_q == FALL_PEND) && (cnt_d == CNT_CFM)));
    end
    push = rise_cfm || fall_cfm;
  end

  // Level FSM with confirm counter; out is registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_V != 0) ? HIGH : LOW;
      cnt_q   <= 4'd0;
      out_q   <= (INIT_V != 0);
    end else if (smp_valid) begin
      case (state_q)
        LOW: begin
          if (rise_cfm) begin
            state_q <= HIGH;
            out_q   <= 1'b1;
            cnt_q   <= 4'd0;
          end else if (is_hi) begin
            state_q <= RISE_PEND;
            cnt_q   <= 4'd1;
          end
        end
        RISE_PEND: begin
          if (rise_cfm) begin
            state_q <= HIGH;
            out_q   <= 1'b1;
            cnt_q   <= 4'd0;
          end else if (is_hi) begin
            cnt_q   <= cnt_d;
          end else begin
            state_q <= LOW;
            cnt_q   <= 4'd0;
          end
        end
        HIGH: begin
          if (fall_cfm) begin
            state_q <= LOW;
            out_q   <= 1'b0;
            cnt_q   <= 4'd0;
          end else if (is_lo) begin
            state_q <= FALL_PEND;
            cnt_q   <= 4'd1;
          end
        end
        default: begin
          if (fall_cfm) begin
            state_q <= LOW;
            out_q   <= 1'b0;
            cnt_q   <= 4'd0;
          end else if (is_lo) begin
            cnt_q   <= cnt_d;
          end else begin
            state_q <= HIGH;
            cnt_q   <= 4'd0;
          end
        end
      endcase
    end
  end

  assign out = out_q;

  // Free-running timestamp, wraps naturally at 2^TS_W
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign full      = (fill_q == 3'd4);
  assign evt_valid = (fill_q != 3'd0);
  assign pop       = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok   = push && (!full || pop);

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      fill_q   <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      fill_q <= fill_q + {2'b00, push_ok} - {2'b00, pop};
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  // Event storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{level: rise_cfm, ts: ts_q};
  end

  assign evt_level = mem_q[rd_ptr_q].level;
  assign evt_ts    = mem_q[rd_ptr_q].ts;
  assign evt_ovf   = ovf_q;

`ifdef A2D_XFLAG_EN
  localparam logic [7:0] XT_C = 8'(X_TIMEOUT);

  logic [7:0] xcnt_q;
  logic [7:0] xcnt_d;
  logic       x_flag_q;
  logic       in_band;

  assign in_band = !is_hi && !is_lo;
  assign xcnt_d  = (xcnt_q == 8'hFF) ? 8'hFF : xcnt_q + 8'd1;

  // Saturating run-length of in-band samples; any valid out-of-band sample clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      xcnt_q   <= 8'd0;
      x_flag_q <= 1'b0;
    end else if (smp_valid) begin
      if (in_band) begin
        xcnt_q   <= xcnt_d;
        x_flag_q <= x_flag_q || (xcnt_d >= XT_C);
      end else begin
        xcnt_q   <= 8'd0;
        x_flag_q <= 1'b0;
      end
    end
  end

  assign x_flag = x_flag_q;
`else
  assign x_flag = 1'b0;
`endif

endmodule
